// File: rtl/stage_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : stage_fetch
//  Purpose  : rv32 instruction fetch stage. Holds the PC, issues word-aligned
//             requests over a req/gnt/rvalid handshake, buffers returned
//             instructions with their PC in an in-order queue and hands them
//             to decode with valid/ready. A redirect from execute flushes the
//             queue and discards every response still in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    localparam logic [c_PW-1:0] c_PONE  = 1;
    localparam logic [c_CW-1:0] c_CONE  = 1;
    localparam logic [c_CW:0]   c_DEPTH = DEPTH[c_CW:0];

    // Program counter
    logic [31:0]     r_pc;

    // Pending-PC FIFO: PCs of granted requests whose response has not returned
    logic [31:0]     r_pend_pc [DEPTH];
    logic [c_PW-1:0] r_pend_wr;
    logic [c_PW-1:0] r_pend_rd;

    // Instruction queue of {pc, instr}
    logic [31:0]     r_q_pc    [DEPTH];
    logic [31:0]     r_q_instr [DEPTH];
    logic [c_PW-1:0] r_q_wr;
    logic [c_PW-1:0] r_q_rd;
    logic [c_CW-1:0] r_q_count;

    // In-flight bookkeeping
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_discard;

    logic [c_CW:0]   w_used;
    logic            w_grant;
    logic            w_resp;
    logic            w_discarding;
    logic            w_push;
    logic            w_pop;
    logic [c_CW-1:0] w_out_next;

    // Credit check: every request in flight already owns a queue slot
    always_comb begin
        w_used     = {1'b0, r_outstanding} + {1'b0, r_q_count};
        imem_req_o = !rst_i && !redirect_valid_i && (w_used < c_DEPTH);
    end

    assign w_grant      = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored
    assign w_resp       = imem_rvalid_i && (r_outstanding != '0);
    assign w_discarding = (r_discard != '0);
    assign w_push       = w_resp && !w_discarding && !redirect_valid_i;
    assign w_pop        = instr_valid_o && instr_ready_i && !redirect_valid_i;

    // Outstanding count after this cycle's grant and response
    always_comb begin
        w_out_next = r_outstanding;
        if (w_grant && !w_resp) begin
            w_out_next = r_outstanding + c_CONE;
        end else if (!w_grant && w_resp) begin
            w_out_next = r_outstanding - c_CONE;
        end
    end

    // PC: redirect target (word aligned), else advance on each grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid_i) begin
            r_pc <= redirect_addr_i & ~32'd3;
        end else if (w_grant) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Pending-PC FIFO: push on grant, pop on every accepted response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_wr <= '0;
            r_pend_rd <= '0;
        end else begin
            if (w_grant) begin
                r_pend_pc[r_pend_wr] <= r_pc;
                r_pend_wr            <= r_pend_wr + c_PONE;
            end
            if (w_resp) begin
                r_pend_rd <= r_pend_rd + c_PONE;
            end
        end
    end

    // Outstanding and discard counters; a redirect marks everything still in
    // flight (after this cycle's response) as to-be-dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid_i) begin
                r_discard <= w_out_next;
            end else if (w_resp && w_discarding) begin
                r_discard <= r_discard - c_CONE;
            end
        end
    end

    // Instruction queue: flushed on redirect, otherwise push/pop independently
    always_ff @(posedge clk_i) begin
        if (rst_i || redirect_valid_i) begin
            r_q_wr    <= '0;
            r_q_rd    <= '0;
            r_q_count <= '0;
        end else begin
            if (w_push) begin
                r_q_pc[r_q_wr]    <= r_pend_pc[r_pend_rd];
                r_q_instr[r_q_wr] <= imem_rdata_i;
                r_q_wr            <= r_q_wr + c_PONE;
            end
            if (w_pop) begin
                r_q_rd <= r_q_rd + c_PONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_q_count <= r_q_count + c_CONE;
                2'b01:   r_q_count <= r_q_count - c_CONE;
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    assign imem_addr_o   = r_pc;
    assign instr_valid_o = (r_q_count != '0);
    assign instr_o       = instr_valid_o ? r_q_instr[r_q_rd] : 32'd0;
    assign instr_pc_o    = instr_valid_o ? r_q_pc[r_q_rd]    : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_stage_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_fetch
//  Purpose  : Self-checking bench for stage_fetch: a directed vector table for
//             reset, stall, grant hold, redirect and PC wrap, followed by a
//             randomized run against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stage_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    stage_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) u_dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_addr_i  (redirect_addr_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_ready_i    (instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          rst;
        bit          redir;
        logic [31:0] raddr;
        bit          gnt;
        bit          rvalid;
        logic [31:0] rdata;
        bit          ready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit redir, input logic [31:0] raddr,
                       input bit gnt, input bit rvalid, input logic [31:0] rdata,
                       input bit ready, input bit e_req, input logic [31:0] e_addr,
                       input bit e_valid, input logic [31:0] e_pc,
                       input logic [31:0] e_instr);
        vec_t v;
        v.rst = rst;     v.redir = redir;   v.raddr = raddr;
        v.gnt = gnt;     v.rvalid = rvalid; v.rdata = rdata;
        v.ready = ready; v.e_req = e_req;   v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        tbl.push_back(v);
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending requests carry a stale flag instead of a
    // discard counter; the instruction queue is a plain SV queue.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    pend_t       m_pend[$];
    ent_t        m_iq[$];
    logic [31:0] m_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    initial begin
        rst_i            = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_addr_i  = 32'd0;
        imem_gnt_i       = 1'b0;
        imem_rvalid_i    = 1'b0;
        imem_rdata_i     = 32'd0;
        instr_ready_i    = 1'b0;

        //   rst redir raddr          gnt rv  rdata          rdy  req addr           vld pc             instr
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0000_0100, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h0000_0100, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          1, 1, 32'hAAAA_0001,  0,   1, 32'h0000_0104, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          1, 1, 32'hAAAA_0002,  0,   0, 32'h0000_0108, 1, 32'h0000_0100, 32'hAAAA_0001);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0,   0, 32'h0000_0108, 1, 32'h0000_0100, 32'hAAAA_0001);
        add(0, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h0000_0108, 1, 32'h0000_0100, 32'hAAAA_0001);
        add(0, 0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h0000_0108, 1, 32'h0000_0104, 32'hAAAA_0002);
        add(0, 0, 32'h0,          0, 1, 32'hAAAA_0003,  1,   1, 32'h0000_010C, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0000_010C, 1, 32'h0000_0108, 32'hAAAA_0003);
        add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0000_010C, 1, 32'h0000_0108, 32'hAAAA_0003);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h0000_010C, 1, 32'h0000_0108, 32'hAAAA_0003);
        add(0, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0000_0110, 1, 32'h0000_0108, 32'hAAAA_0003);
        add(0, 0, 32'h0,          0, 1, 32'hAAAA_0004,  1,   0, 32'h0000_0110, 1, 32'h0000_0108, 32'hAAAA_0003);
        add(0, 0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h0000_0110, 1, 32'h0000_010C, 32'hAAAA_0004);
        add(0, 0, 32'h0,          1, 1, 32'hAAAA_0005,  1,   1, 32'h0000_0114, 0, 32'h0,          32'h0);
        // redirect with one entry queued and one request in flight
        add(0, 1, 32'h0000_2003,  1, 0, 32'h0,          1,   0, 32'h0000_0118, 1, 32'h0000_0110, 32'hAAAA_0005);
        add(0, 0, 32'h0,          0, 1, 32'hDEAD_0006,  1,   1, 32'h0000_2000, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h0000_2000, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          0, 1, 32'hBBBB_0000,  0,   1, 32'h0000_2004, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          0, 0, 32'h0,          1,   1, 32'h0000_2004, 1, 32'h0000_2000, 32'hBBBB_0000);
        add(0, 0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h0000_2004, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          0, 1, 32'hBBBB_0004,  1,   1, 32'h0000_2008, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h0000_2008, 1, 32'h0000_2004, 32'hBBBB_0004);
        // redirect coinciding with a response and a pop
        add(0, 1, 32'h0000_3000,  1, 1, 32'hDEAD_0008,  1,   0, 32'h0000_200C, 1, 32'h0000_2004, 32'hBBBB_0004);
        add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0000_3000, 0, 32'h0,          32'h0);
        // PC wrap at the top of the address space
        add(0, 1, 32'hFFFF_FFFE,  0, 0, 32'h0,          0,   0, 32'h0000_3000, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0000_0000, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          0, 1, 32'hCCCC_0000,  0,   1, 32'h0000_0000, 0, 32'h0,          32'h0);
        // stray response with nothing outstanding
        add(0, 0, 32'h0,          0, 1, 32'hDEAD_0009,  0,   1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hCCCC_0000);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hCCCC_0000);
        // reset mid-stream, then a late response from before reset
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0000_0004, 1, 32'hFFFF_FFFC, 32'hCCCC_0000);
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0000_0100, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          0, 1, 32'hDEAD_000A,  0,   1, 32'h0000_0100, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0000_0100, 0, 32'h0,          32'h0);

        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_i            = tbl[i].rst;
            redirect_valid_i = tbl[i].redir;
            redirect_addr_i  = tbl[i].raddr;
            imem_gnt_i       = tbl[i].gnt;
            imem_rvalid_i    = tbl[i].rvalid;
            imem_rdata_i     = tbl[i].rdata;
            instr_ready_i    = tbl[i].ready;
            #1;
            chk("tbl_req",   i, {31'd0, imem_req_o},    {31'd0, tbl[i].e_req});
            chk("tbl_addr",  i, imem_addr_o,            tbl[i].e_addr);
            chk("tbl_valid", i, {31'd0, instr_valid_o}, {31'd0, tbl[i].e_valid});
            chk("tbl_pc",    i, instr_pc_o,             tbl[i].e_pc);
            chk("tbl_instr", i, instr_o,                tbl[i].e_instr);
        end

        // ------------------------------------------------------------------
        // Randomized run against the reference model
        // ------------------------------------------------------------------
        m_pc = RESET_PC;
        m_pend.delete();
        m_iq.delete();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          e_req;
            bit          e_valid;
            logic [31:0] e_pc;
            logic [31:0] e_instr;
            bit          grant;
            bit          pop;
            pend_t       p;

            @(negedge clk);
            rst_i            = (cyc == 0) || ($urandom_range(0, 199) == 0);
            redirect_valid_i = !rst_i && ($urandom_range(0, 19) == 0);
            redirect_addr_i  = ($urandom_range(0, 3) == 0)
                               ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                               : 32'($urandom);
            imem_gnt_i       = ($urandom_range(0, 3) != 0);
            instr_ready_i    = ($urandom_range(0, 9) < 7);
            imem_rdata_i     = 32'($urandom);
            imem_rvalid_i    = 1'b0;
            if (m_pend.size() > 0) begin
                if (m_pend[0].due <= cyc && $urandom_range(0, 3) != 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_data(m_pend[0].addr);
                end
            end else if ($urandom_range(0, 19) == 0) begin
                imem_rvalid_i = 1'b1;
            end
            #1;

            e_req   = !rst_i && !redirect_valid_i && (m_pend.size() + m_iq.size() < DEPTH);
            e_valid = (m_iq.size() > 0);
            e_pc    = e_valid ? m_iq[0].pc    : 32'd0;
            e_instr = e_valid ? m_iq[0].instr : 32'd0;

            chk("rnd_req",   cyc, {31'd0, imem_req_o},    {31'd0, e_req});
            chk("rnd_addr",  cyc, imem_addr_o,            m_pc);
            chk("rnd_valid", cyc, {31'd0, instr_valid_o}, {31'd0, e_valid});
            chk("rnd_pc",    cyc, instr_pc_o,             e_pc);
            chk("rnd_instr", cyc, instr_o,                e_instr);

            // advance the model across the coming clock edge
            if (rst_i) begin
                m_pc = RESET_PC;
                m_pend.delete();
                m_iq.delete();
            end else begin
                grant = e_req && imem_gnt_i;
                pop   = e_valid && instr_ready_i && !redirect_valid_i;
                if (pop) void'(m_iq.pop_front());
                if (imem_rvalid_i && m_pend.size() > 0) begin
                    p = m_pend.pop_front();
                    if (!p.stale && !redirect_valid_i) begin
                        m_iq.push_back('{pc: p.addr, instr: imem_rdata_i});
                    end
                end
                if (redirect_valid_i) begin
                    m_pc = {redirect_addr_i[31:2], 2'b00};
                    m_iq.delete();
                    foreach (m_pend[k]) m_pend[k].stale = 1'b1;
                end else if (grant) begin
                    m_pend.push_back('{addr: m_pc,
                                       due: cyc + 1 + int'($urandom_range(0, 2)),
                                       stale: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
